// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared widths, state codes and command-word layout for the DMA descriptor path
package dma_pkg;

    localparam int ADDR_W = 32;
    localparam int XFER_W = 16;
    localparam int LEN_W  = 24;
    localparam int CMD_W  = XFER_W + ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Same bit order as the command FIFO word: {bytes, addr}
    typedef struct packed {
        logic [XFER_W-1:0] bytes;
        logic [ADDR_W-1:0] addr;
    } dma_cmd_t;

endpackage

// File: rtl/dma_chunk_calc.sv
// rtl/dma_chunk_calc.sv - size of the next chunk and whether it finishes the descriptor
module dma_chunk_calc
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK_BYTES = 4096
) (
    input  logic [LEN_W-1:0]  remaining,
    output logic [XFER_W-1:0] chunk,
    output logic              last
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNK_BYTES);

    // MAX_CHUNK_BYTES <= 32768, so either choice fits the 16-bit transfer field
    assign last  = (remaining <= MAX_LEN);
    assign chunk = last ? remaining[XFER_W-1:0] : MAX_LEN[XFER_W-1:0];

endmodule

// File: rtl/dma_desc_processor.sv
// rtl/dma_desc_processor.sv - splits copy descriptors into paired read/write chunk commands
module dma_desc_processor
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK_BYTES = 4096,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [ADDR_W-1:0] desc_src_addr_i,
    input  logic [ADDR_W-1:0] desc_dst_addr_i,
    input  logic [LEN_W-1:0]  desc_len_i,
    input  logic              desc_abort_i,
    output logic              dma_rd_fifo_command_req_o,
    output logic [XFER_W-1:0] dma_rd_bytes_to_transfer_o,
    output logic [ADDR_W-1:0] dma_rd_addr_o,
    input  logic              dma_rd_fifo_full_i,
    output logic              dma_wr_fifo_command_req_o,
    output logic [XFER_W-1:0] dma_wr_bytes_to_transfer_o,
    output logic [ADDR_W-1:0] dma_wr_addr_o,
    input  logic              dma_wr_fifo_full_i,
    output logic              busy_o,
    output logic              desc_done_o,
    output logic              desc_aborted_o,
    output logic [CNT_W-1:0]  desc_count_o
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic              aborted_q;
    logic [CNT_W-1:0]  count_q;

    logic [XFER_W-1:0] chunk;
    logic              last;
    logic              fire;
    dma_cmd_t          rd_cmd;
    dma_cmd_t          wr_cmd;

    dma_chunk_calc #(
        .MAX_CHUNK_BYTES(MAX_CHUNK_BYTES)
    ) u_chunk_calc (
        .remaining(rem_q),
        .chunk    (chunk),
        .last     (last)
    );

    // Both FIFOs must have room so the read and write sides never diverge
    assign fire = (state == ST_ISSUE) && !desc_abort_i
               && !dma_rd_fifo_full_i && !dma_wr_fifo_full_i;

    always_comb begin
        rd_cmd = '0;
        wr_cmd = '0;
        if (fire) begin
            rd_cmd.bytes = chunk;
            rd_cmd.addr  = src_q;
            wr_cmd.bytes = chunk;
            wr_cmd.addr  = dst_q;
        end
    end

    assign dma_rd_fifo_command_req_o  = fire;
    assign dma_wr_fifo_command_req_o  = fire;
    assign dma_rd_bytes_to_transfer_o = rd_cmd.bytes;
    assign dma_rd_addr_o              = rd_cmd.addr;
    assign dma_wr_bytes_to_transfer_o = wr_cmd.bytes;
    assign dma_wr_addr_o              = wr_cmd.addr;

    assign desc_ready_o   = (state == ST_IDLE);
    assign busy_o         = (state == ST_ISSUE);
    assign desc_done_o    = (state == ST_DONE);
    assign desc_aborted_o = (state == ST_DONE) && aborted_q;
    assign desc_count_o   = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (desc_valid_i) begin
                        src_q     <= desc_src_addr_i;
                        dst_q     <= desc_dst_addr_i;
                        rem_q     <= desc_len_i;
                        aborted_q <= 1'b0;
                        if (desc_len_i == '0) begin
                            state   <= ST_DONE;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (desc_abort_i) begin
                        state     <= ST_DONE;
                        aborted_q <= 1'b1;
                    end else if (fire) begin
                        src_q <= src_q + ADDR_W'(chunk);
                        dst_q <= dst_q + ADDR_W'(chunk);
                        rem_q <= rem_q - LEN_W'(chunk);
                        if (last) begin
                            state   <= ST_DONE;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_processor.sv
// tb/tb_dma_desc_processor.sv - randomized self-checking bench for dma_desc_processor
module tb_dma_desc_processor;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_src;
    logic [31:0] desc_dst;
    logic [23:0] desc_len;
    logic        desc_abort;
    logic        rd_req;
    logic [15:0] rd_bytes;
    logic [31:0] rd_addr;
    logic        rd_full;
    logic        wr_req;
    logic [15:0] wr_bytes;
    logic [31:0] wr_addr;
    logic        wr_full;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_count = '0;

    dma_desc_processor #(.MAX_CHUNK_BYTES(MAXC), .CNT_W(16)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .desc_valid_i              (desc_valid),
        .desc_ready_o              (desc_ready),
        .desc_src_addr_i           (desc_src),
        .desc_dst_addr_i           (desc_dst),
        .desc_len_i                (desc_len),
        .desc_abort_i              (desc_abort),
        .dma_rd_fifo_command_req_o (rd_req),
        .dma_rd_bytes_to_transfer_o(rd_bytes),
        .dma_rd_addr_o             (rd_addr),
        .dma_rd_fifo_full_i        (rd_full),
        .dma_wr_fifo_command_req_o (wr_req),
        .dma_wr_bytes_to_transfer_o(wr_bytes),
        .dma_wr_addr_o             (wr_addr),
        .dma_wr_fifo_full_i        (wr_full),
        .busy_o                    (busy),
        .desc_done_o               (done),
        .desc_aborted_o            (aborted),
        .desc_count_o              (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 FIFOs free, 1 random back-pressure, 2 write FIFO full for 5 cycles
    task automatic run_desc(input logic [31:0] s, input logic [31:0] d, input logic [23:0] l,
                            input int mode, input int abort_at);
        logic [31:0] es[$];
        logic [31:0] ed[$];
        logic [15:0] eb[$];
        logic [31:0] a = s;
        logic [31:0] b = d;
        int remaining = int'(l);
        int idx = 0;
        int cyc = 0;
        bit seen_done = 0;
        bit will_abort;
        int exp_issued;
        int c;
        while (remaining > 0) begin
            c = (remaining < MAXC) ? remaining : MAXC;
            es.push_back(a);
            ed.push_back(b);
            eb.push_back(16'(c));
            a = a + 32'(c);
            b = b + 32'(c);
            remaining -= c;
        end
        will_abort = (abort_at >= 0) && (abort_at < es.size());
        exp_issued = will_abort ? abort_at : es.size();

        @(negedge clk);
        desc_valid = 1'b1;
        desc_src   = s;
        desc_dst   = d;
        desc_len   = l;
        #1;
        check("accept_ready", desc_ready, 1'b1);
        while (!seen_done && cyc < 4000) begin
            @(negedge clk);
            desc_valid = 1'b0;
            cyc++;
            rd_full = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            wr_full = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && cyc <= 5);
            desc_abort = will_abort && (idx == abort_at);
            #1;
            if (done) begin
                seen_done = 1;
                check("aborted_flag", aborted, will_abort);
                check("done_not_busy", busy, 1'b0);
            end else begin
                check("strobe_pair", wr_req, rd_req);
                if (rd_req) begin
                    if (idx < es.size()) begin
                        check("rd_addr", rd_addr, es[idx]);
                        check("wr_addr", wr_addr, ed[idx]);
                        check("rd_bytes", rd_bytes, eb[idx]);
                        check("wr_bytes", wr_bytes, eb[idx]);
                    end else begin
                        check("extra_cmd", 1'b1, 1'b0);
                    end
                    idx++;
                end else begin
                    check("idle_bytes", rd_bytes, 16'h0);
                end
                if (rd_full || wr_full || desc_abort)
                    check("stall_no_strobe", rd_req, 1'b0);
            end
        end
        desc_abort = 1'b0;
        rd_full    = 1'b0;
        wr_full    = 1'b0;
        check("done_seen", seen_done, 1'b1);
        check("cmd_count", idx, exp_issued);
        if (!will_abort && mode == 0) check("latency", cyc, es.size() + 1);
        if (!will_abort && mode == 2) check("stall_latency", cyc, es.size() + 6);
        if (!will_abort) exp_count++;
        @(negedge clk);
        #1;
        check("desc_count", count, exp_count);
        check("back_idle", desc_ready, 1'b1);
    endtask

    initial begin
        logic [23:0] l;
        int pick;
        int hold;
        reset_n    = 1'b0;
        desc_valid = 1'b0;
        desc_src   = '0;
        desc_dst   = '0;
        desc_len   = '0;
        desc_abort = 1'b0;
        rd_full    = 1'b0;
        wr_full    = 1'b0;
        #12;
        check("rst_ready", desc_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", count, 16'h0);
        check("rst_strobe", rd_req | wr_req, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        run_desc(32'h1000, 32'h8000, 24'h2800, 0, -1);
        run_desc(32'h1234, 32'h5678, 24'h0, 0, -1);
        run_desc(32'h4000, 32'hC000, 24'h3000, 2, -1);
        run_desc(32'h4000, 32'hC000, 24'h3000, 0, 1);
        run_desc(32'hFFFF_F000, 32'h10, 24'h2000, 0, -1);
        run_desc(32'h0, 32'h0, 24'h1000, 0, -1);
        run_desc(32'h0, 32'h0, 24'h1, 0, -1);

        // Abort while idle must neither block acceptance nor touch the count
        @(negedge clk);
        desc_abort = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_abort_ready", desc_ready, 1'b1);
        check("idle_abort_count", count, exp_count);
        desc_abort = 1'b0;

        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0: l = 24'h0;
                1: l = 24'($urandom_range(1, 64));
                2: l = 24'(MAXC * $urandom_range(1, 4));
                default: l = 24'($urandom_range(1, 24'h6000));
            endcase
            run_desc($urandom, $urandom, l, $urandom_range(0, 1),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        // Asynchronous reset in the middle of ISSUE
        @(negedge clk);
        desc_valid = 1'b1;
        desc_src   = 32'h2000;
        desc_dst   = 32'h9000;
        desc_len   = 24'h3000;
        @(negedge clk);
        desc_valid = 1'b0;
        #1;
        check("pre_rst_strobe", rd_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", rd_req, 1'b0);
        check("async_rst_wr", wr_req, 1'b0);
        check("async_rst_ready", desc_ready, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_count", count, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        hold = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (done || rd_req || wr_req) hold++;
        end
        check("post_rst_quiet", hold, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
